load_store_unit: RTL and testbench

Sits between the MIPS datapath's memory stage and the word-organised `data_memory`, turning byte/halfword/word loads and stores into word accesses. Sub-word stores use a read-modify-write sequence. Loaded values are sign- or zero-extended. Misaligned, out-of-range and reserved-size requests are reported as faults and never touch memory.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit and its lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  localparam int unsigned LSU_MEM_WORDS = 100;

  // Alignment rule only; the range check depends on the memory size of the instance.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane muxing: extracts/extends load data and merges sub-word store data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h000000, byte_lane}
                                       : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = is_unsigned ? {16'h0000, half_lane}
                                       : {{16{half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  // Only the addressed lane takes store data; the rest keeps the word read from memory.
  always_comb begin
    merge_data = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merge_data[7:0]   = wdata[7:0];
          2'd1: merge_data[15:8]  = wdata[7:0];
          2'd2: merge_data[23:16] = wdata[7:0];
          2'd3: merge_data[31:24] = wdata[7:0];
          default: merge_data = word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merge_data[31:16] = wdata[15:0];
        else           merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-organised data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state, state_next;
  logic        we_q, uns_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, merge_q;
  logic        accept, req_fault, is_word_store;
  logic [31:0] load_data, merge_data;

  assign accept        = (state == ST_IDLE) && req_valid;
  assign req_fault     = size_misaligned(req_size, req_addr[1:0]) ||
                         ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  assign is_word_store = we_q && (size_q == SZ_WORD);

  lsu_lane_align u_lane_align (
    .word        (mem_rd),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = req_fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_next = (we_q && !is_word_store) ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory strobes are decoded from state so an async reset drops them immediately.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 32'h0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        if (is_word_store && !fault_q) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        mem_wd = merge_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
      end
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        fault_q <= req_fault;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ST_ACCESS) begin
        if (!we_q) rdata_q <= load_data;
        else       merge_q <= merge_data;
      end
    end
  end

  assign mem_a = {2'b00, addr_q[31:2]};

  // Load data persists between load responses; store and fault responses read as zero.
  assign resp_rdata = ((state == ST_RESP) && (we_q || fault_q)) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a bench-owned word memory and reference model.
module tb_load_store_unit;

  localparam int MW = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] ram     [MW];
  logic [31:0] ref_ram [MW];
  logic        bd_sync = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  always #5 clk = ~clk;

  // Bench memory: not cleared by reset, so a stray write would remain visible.
  assign mem_rd = (mem_a < MW) ? ram[mem_a[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_sync) begin
      for (int i = 0; i < MW; i++) ram[i] <= ref_ram[i];
    end else if (mem_we && (mem_a < MW)) begin
      ram[mem_a[6:0]] <= mem_wd;
    end
  end

  // Reference model: rules expressed as byte arithmetic on whole words.
  function automatic logic model_fault(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nbytes;
    if (size == 2'b11) return 1'b1;
    nbytes = 32'd1 << size;
    if ((addr % nbytes) != 0) return 1'b1;
    return (addr / 4) >= MW;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    longint unsigned v, mask;
    int nbits;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    v     = ({32'h0, word} >> (8 * (addr % 4))) & mask;
    if (!uns && (((v >> (nbits - 1)) & 64'd1) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wdata);
    longint unsigned v, mask;
    int nbits, sh;
    nbits = 8 << size;
    sh    = 8 * (addr % 4);
    mask  = ((64'd1 << nbits) - 64'd1) << sh;
    v     = ({32'h0, old} & ~mask) | (({32'h0, wdata} << sh) & mask);
    return v[31:0];
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] val);
    ref_ram[idx] = val;
    bd_sync = 1'b1;
    @(posedge clk); #1;
    bd_sync = 1'b0;
  endtask

  // Drives one request and records what the unit does until its response and one cycle after.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic fault,
                        output logic [8:0] we_seen, output logic a_bad,
                        output logic [31:0] idle_rdata);
    int waitc;
    lat = 0; rdata = 32'h0; fault = 1'b0; we_seen = 9'h0; a_bad = 1'b0; idle_rdata = 32'h0;
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int n = 1; n <= 8; n++) begin
      if (mem_we) we_seen[n] = 1'b1;
      if (mem_a !== {2'b00, addr[31:2]}) a_bad = 1'b1;
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; fault = resp_fault;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_rdata = resp_rdata;
  endtask

  task automatic test_reset;
    for (int i = 0; i < MW; i++) ref_ram[i] = $urandom;
    reset_n = 1'b0;
    bd_sync = 1'b1;
    @(posedge clk); #1;
    bd_sync = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_fault !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_resp_fault got %b want 0", resp_fault); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_mem_a got %h want 0", mem_a); end
    n_cmp++; if (mem_wd !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_mem_wd got %h want 0", mem_wd); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_round_trip;
    int lat; logic [31:0] rd, idle; logic flt, abad; logic [8:0] wes;
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, flt, wes, abad, idle);
    ref_ram[2] = 32'hDEADBEEF;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("[TB] FAIL sw_latency got %0d want 2", lat); end
    n_cmp++; if (wes !== 9'b000000010) begin n_bad++; $display("[TB] FAIL sw_we_cycles got %b want 000000010", wes); end
    n_cmp++; if (rd !== 32'h0 || flt !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_resp got rdata=%h fault=%b want 0/0", rd, flt); end
    n_cmp++; if (ram[2] !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL sw_ram2 got %h want deadbeef", ram[2]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, flt, wes, abad, idle);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("[TB] FAIL lw_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL lw_rdata got %h want deadbeef", rd); end
    n_cmp++; if (wes !== 9'h0) begin n_bad++; $display("[TB] FAIL lw_we_cycles got %b want 0", wes); end
    n_cmp++; if (abad !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mem_a_stable got %b want 0", abad); end
  endtask

  task automatic test_subword_rmw;
    int lat; logic [31:0] rd, idle; logic flt, abad; logic [8:0] wes;
    bd_write(1, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h123456AA, lat, rd, flt, wes, abad, idle);
    ref_ram[1] = 32'h11AA3344;
    n_cmp++; if (lat !== 3) begin n_bad++; $display("[TB] FAIL sb_latency got %0d want 3", lat); end
    n_cmp++; if (wes !== 9'b000000100) begin n_bad++; $display("[TB] FAIL sb_we_cycles got %b want 000000100", wes); end
    n_cmp++; if (ram[1] !== 32'h11AA3344) begin n_bad++; $display("[TB] FAIL sb_ram1 got %h want 11aa3344", ram[1]); end
  endtask

  task automatic test_extension;
    int lat; logic [31:0] rd, idle; logic flt, abad; logic [8:0] wes;
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [4] = '{32'h2, 32'h2, 32'h2, 32'h0};
    logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h00007F01};
    bd_write(0, 32'h80F07F01);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, flt, wes, abad, idle);
      n_cmp++; if (rd !== exp[i] || lat !== 2) begin n_bad++; $display("[TB] FAIL ext_load%0d got %h lat %0d want %h lat 2", i, rd, lat, exp[i]); end
    end
  endtask

  task automatic test_faults;
    int lat, bad; logic [31:0] rd, idle; logic flt, abad; logic [8:0] wes;
    logic        we [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] ad [4] = '{32'h3, 32'h2, 32'h190, 32'h10};
    for (int i = 0; i < 4; i++) begin
      do_req(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat, rd, flt, wes, abad, idle);
      n_cmp++; if (flt !== 1'b1 || lat !== 1) begin n_bad++; $display("[TB] FAIL fault%0d got fault=%b lat=%0d want 1/1", i, flt, lat); end
      n_cmp++; if (wes !== 9'h0 || rd !== 32'h0) begin n_bad++; $display("[TB] FAIL fault%0d_side got we=%b rdata=%h want 0/0", i, wes, rd); end
    end
    bad = 0;
    for (int i = 0; i < MW; i++) if (ram[i] !== ref_ram[i]) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("[TB] FAIL fault_ram_unchanged got %0d differing words want 0", bad); end
  endtask

  task automatic test_reset_mid_rmw;
    logic [31:0] exp_wd;
    bd_write(1, 32'h55667788);
    exp_wd = model_store(32'h55667788, 32'h4, 2'b00, 32'h99);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_we !== 1'b1 || mem_wd !== exp_wd) begin n_bad++; $display("[TB] FAIL rmw_write_cycle got we=%b wd=%h want 1/%h", mem_we, mem_wd, exp_wd); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_reset_outputs got ready=%b valid=%b we=%b want 1/0/0", req_ready, resp_valid, mem_we); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ram[1] !== 32'h55667788) begin n_bad++; $display("[TB] FAIL rmw_ram1 got %h want 55667788", ram[1]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] la [3] = '{32'h28, 32'h2E, 32'h31};
    logic [1:0]  ls [3] = '{2'b10, 2'b01, 2'b00};
    logic [31:0] exp [3];
    logic [31:0] got_q[$];
    int acc [3];
    int k, bad;
    for (int i = 0; i < 3; i++) exp[i] = model_load(ref_ram[la[i] >> 2], la[i], ls[i], 1'b0);
    k = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = ls[0]; req_unsigned = 1'b0; req_addr = la[0];
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_ready && req_valid) begin
        if (k < 3) acc[k] = cyc;
        k++;
      end
      @(posedge clk); #1;
      if (resp_valid) got_q.push_back(resp_rdata);
      if (req_ready && k < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = ls[k]; req_unsigned = 1'b0; req_addr = la[k];
      end else if (req_ready) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'($urandom_range(0, MW - 1)) << 2; req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (k !== 3) begin n_bad++; $display("[TB] FAIL b2b_accepts got %0d want 3", k); end
    n_cmp++; if (k >= 3 && (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)) begin n_bad++; $display("[TB] FAIL b2b_spacing got %0d,%0d want 3,3", acc[1] - acc[0], acc[2] - acc[1]); end
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("[TB] FAIL b2b_responses got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp[i]) begin n_bad++; $display("[TB] FAIL b2b_rdata%0d got %h want %h", i, got_q[i], exp[i]); end
    end
    bad = 0;
    for (int i = 0; i < MW; i++) if (ram[i] !== ref_ram[i]) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("[TB] FAIL b2b_ram_untouched got %0d differing words want 0", bad); end
  endtask

  task automatic test_random;
    int lat, exp_lat, bad, idx; logic [31:0] rd, idle, addr, wdata, exp_rd, last_load;
    logic flt, abad, we, uns, exp_fault, have_load; logic [8:0] wes, exp_we; logic [1:0] size;
    have_load = 1'b0; last_load = 32'h0;
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom);
      uns   = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
      else addr = (32'($urandom_range(0, MW - 1)) << 2) | 32'($urandom_range(0, 3));
      exp_fault = model_fault(size, addr);
      exp_rd = 32'h0; exp_we = 9'h0;
      if (exp_fault) exp_lat = 1;
      else begin
        idx = int'(addr >> 2);
        if (!we) begin
          exp_lat = 2;
          exp_rd = model_load(ref_ram[idx], addr, size, uns);
        end else begin
          exp_lat = (size == 2'b10) ? 2 : 3;
          exp_we[exp_lat - 1] = 1'b1;
          ref_ram[idx] = model_store(ref_ram[idx], addr, size, wdata);
        end
      end
      do_req(we, size, uns, addr, wdata, lat, rd, flt, wes, abad, idle);
      n_cmp++; if (flt !== exp_fault || lat !== exp_lat) begin n_bad++; $display("[TB] FAIL rnd%0d_resp got fault=%b lat=%0d want %b/%0d", i, flt, lat, exp_fault, exp_lat); end
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("[TB] FAIL rnd%0d_rdata got %h want %h", i, rd, exp_rd); end
      n_cmp++; if (wes !== exp_we || abad !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd%0d_mem got we=%b abad=%b want %b/0", i, wes, abad, exp_we); end
      if (!exp_fault && !we) begin have_load = 1'b1; last_load = exp_rd; end
      if (have_load) begin
        n_cmp++; if (idle !== last_load) begin n_bad++; $display("[TB] FAIL rnd%0d_rdata_hold got %h want %h", i, idle, last_load); end
      end
    end
    bad = 0;
    for (int i = 0; i < MW; i++) if (ram[i] !== ref_ram[i]) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("[TB] FAIL rnd_ram_contents got %0d differing words want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_word_round_trip;
    test_subword_rmw;
    test_extension;
    test_faults;
    test_reset_mid_rmw;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
